// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;  // MOV r0,r0
   localparam logic [31:0] PC_STEP           = 32'd4;

   // Fetch FSM encodings
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   // One buffered fetch: address and the word read from it
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read channel: req/addr out, ack/rdata back.
interface instr_fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} fetch entries with flush.
module instr_fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  fetch_entry_t                   wdata,
   input  logic                           pop,
   input  logic                           flush,
   output fetch_entry_t                   rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];
   assign do_pop = pop && !empty;

   // Next-state for storage, pointers and occupancy; flush wins over push/pop
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // FIFO state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC/request FSM, fetch buffer and registered decoder output.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall_if,
   input  logic                branch_valid,
   input  logic [31:0]         branch_target,
   instr_fetch_if.master       imem,
   output logic [31:0]         instruction,
   output logic                instr_valid,
   output logic [31:0]         pc_out
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [1:0]       state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      target_q, target_d;
   logic [31:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic [31:0]      pc_q, pc_d;

   logic             req_gate;
   logic             req_ack;
   logic             fetch_done;
   logic [31:0]      branch_pc;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_wdata, fifo_rdata;

   // Only request when the returning word is guaranteed a FIFO slot
   assign req_gate  = (32'(fifo_count) + 32'd1) <= FIFO_DEPTH;
   assign branch_pc = word_align(branch_target);

   // Memory request: drain must keep req up until the pending ack arrives
   always_comb begin
      imem.imem_req  = ((state_q == S_REQ) && req_gate) || (state_q == S_DRAIN);
      imem.imem_addr = fetch_pc_q;
   end

   assign req_ack    = imem.imem_req && imem.imem_ack;
   assign fifo_push  = fetch_done && !fifo_full;
   assign fifo_wdata = '{pc: fetch_pc_q, instr: imem.imem_rdata};

   // Fetch FSM and PC/target next-state
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      target_d   = target_q;
      fetch_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (branch_valid) fetch_pc_d = branch_pc;
         end
         S_REQ: begin
            if (branch_valid) begin
               if (imem.imem_req && !imem.imem_ack) begin
                  // Request already visible to memory; wait for its ack, then redirect
                  state_d  = S_DRAIN;
                  target_d = branch_pc;
               end else begin
                  fetch_pc_d = branch_pc;
               end
            end else if (req_ack) begin
               fetch_done = 1'b1;
               fetch_pc_d = fetch_pc_q + PC_STEP;
            end
         end
         S_DRAIN: begin
            if (branch_valid) target_d = branch_pc;
            if (req_ack) begin
               state_d    = S_REQ;
               fetch_pc_d = branch_valid ? branch_pc : target_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output register: branch flushes even under stall, stall holds, else pop or bubble
   always_comb begin
      instr_d  = instr_q;
      valid_d  = valid_q;
      pc_d     = pc_q;
      fifo_pop = 1'b0;
      if (branch_valid) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!stall_if) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            instr_d  = fifo_rdata.instr;
            pc_d     = fifo_rdata.pc;
            valid_d  = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   // Fetch control and output state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         target_q   <= RESET_PC;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
         pc_q       <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         target_q   <= target_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         pc_q       <= pc_d;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_q;

   instr_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .flush (branch_valid),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Request gating must make an ack into a full buffer impossible
   push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
      !(fetch_done && fifo_full));

endmodule
